// File: rtl/synth_audio_pkg.sv
// Shared audio-path types and constants for the NCO and the I2S transmitter.
package synth_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
    localparam int H_W      = $clog2(4 * SLOT_W);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Bit carried in slot position k: one-BCLK I2S delay, MSB first, zero padding after the LSB.
    function automatic logic slot_bit(input sample_t word, input int k);
        logic bit_v;
        if ((k >= 1) && (k <= SAMPLE_W)) begin
            bit_v = word[SAMPLE_W - k];
        end else begin
            bit_v = 1'b0;
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S master transmitter: serialises the mono sample into both 32-bit slots of a frame,
// paced by the clk_div half-period enable.
module i2s_tx
    import synth_audio_pkg::*;
(
    input  logic    master_clk,
    input  logic    rst,
    input  logic    sample_clk_en,
    input  logic    bit_clk_en,
    input  logic    mute,
    input  sample_t sample_in,
    output logic    i2s_bclk,
    output logic    i2s_lrclk,
    output logic    i2s_sdata,
    output logic    frame_start,
    output logic    underrun
);

    localparam logic [H_W-1:0] H_MAX = H_W'(4 * SLOT_W - 1);

    logic [H_W-1:0] h_q, h_d;
    sample_t        hold_q, hold_d;
    sample_t        frame_word_q, frame_word_d;
    logic           fresh_q, fresh_d;
    logic           bclk_q, bclk_d;
    logic           lrclk_q, lrclk_d;
    logic           sdata_q, sdata_d;
    logic           frame_start_q, frame_start_d;
    logic           underrun_q, underrun_d;
    logic [H_W-2:0] b_s;
    int             k_s;

    assign b_s = h_q[H_W-1:1];
    assign k_s = int'(b_s) % SLOT_W;

    // Next-state: sample capture, half-period counter, pin drive and frame load.
    always_comb begin
        h_d           = h_q;
        hold_d        = hold_q;
        frame_word_d  = frame_word_q;
        fresh_d       = fresh_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (sample_clk_en) begin
            hold_d  = sample_in;
            fresh_d = 1'b1;
        end else begin
            hold_d  = hold_q;
        end

        if (bit_clk_en) begin
            h_d = (h_q == H_MAX) ? '0 : h_q + H_W'(1);
            if (h_q[0] == 1'b0) begin
                bclk_d  = 1'b0;
                lrclk_d = (int'(b_s) >= SLOT_W);
                sdata_d = slot_bit(frame_word_q, k_s);
            end else begin
                bclk_d  = 1'b1;
            end
            // The load overrides the capture's fresh flag: a same-cycle sample is consumed immediately.
            if (h_q == '0) begin
                frame_word_d  = mute ? '0 : (sample_clk_en ? sample_in : hold_q);
                frame_start_d = 1'b1;
                underrun_d    = !fresh_q && !sample_clk_en;
                fresh_d       = 1'b0;
            end else begin
                frame_word_d  = frame_word_q;
            end
        end else begin
            h_d = h_q;
        end
    end

    // State and output registers.
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            h_q           <= '0;
            hold_q        <= '0;
            frame_word_q  <= '0;
            fresh_q       <= 1'b0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            h_q           <= h_d;
            hold_q        <= hold_d;
            frame_word_q  <= frame_word_d;
            fresh_q       <= fresh_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_sdata   = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Frame-level bench for i2s_tx: per-frame stimulus/expectation table, scoreboard of frame words,
// bit-by-bit SDATA/LRCLK check at every rising BCLK, plus an asynchronous reset sequence.
module tb_i2s_tx;

    localparam int MODE_NONE = 0;
    localparam int MODE_PRE  = 1;
    localparam int MODE_COIN = 2;
    localparam int NVEC      = 16;

    typedef struct {
        int          mode;
        logic [15:0] smp;
        logic        mute;
        logic [15:0] exp_word;
        logic        exp_ur;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        ur;
    } exp_t;

    logic        master_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_clk_en = 1'b0;
    logic        bit_clk_en = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl [NVEC];
    exp_t exq [$];

    logic [15:0] cur_word = 16'h0000;
    logic        have_frame = 1'b0;
    logic        prev_bclk = 1'b0;
    logic        prev_fs = 1'b0;
    int          en_cnt = 0;
    int          rises = 0;
    int          frames_seen = 0;

    i2s_tx dut (
        .master_clk    (master_clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .bit_clk_en    (bit_clk_en),
        .mute          (mute),
        .sample_in     (sample_in),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    always #5 master_clk = ~master_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bclk"},   {31'd0, i2s_bclk},    32'd0);
        chk({tag, "_lrclk"},  {31'd0, i2s_lrclk},   32'd0);
        chk({tag, "_sdata"},  {31'd0, i2s_sdata},   32'd0);
        chk({tag, "_fstart"}, {31'd0, frame_start}, 32'd0);
        chk({tag, "_urun"},   {31'd0, underrun},    32'd0);
    endtask

    // Called #1 after each edge; en_at_edge is the bit_clk_en value the DUT just sampled.
    task automatic monitor(input logic en_at_edge);
        exp_t e;
        int   k;
        logic exp_bit;
        if (en_at_edge) en_cnt++;
        chk("fstart_twice", {31'd0, frame_start & prev_fs}, 32'd0);
        if (frame_start) begin
            if (have_frame) begin
                chk("en_per_frame", en_cnt, 32'd128);
                chk("bclk_rises_per_frame", rises, 32'd64);
            end
            if (exq.size() == 0) begin
                chk("unexpected_frame_start", 32'd1, 32'd0);
            end else begin
                e = exq.pop_front();
                chk("underrun", {31'd0, underrun}, {31'd0, e.ur});
                cur_word = e.word;
            end
            have_frame = 1'b1;
            en_cnt = 0;
            rises = 0;
            frames_seen++;
        end else begin
            chk("underrun_stray", {31'd0, underrun}, 32'd0);
        end
        if (i2s_bclk && !prev_bclk && have_frame) begin
            k = rises % 32;
            exp_bit = ((k >= 1) && (k <= 16)) ? cur_word[16 - k] : 1'b0;
            chk($sformatf("sdata_w%04h_r%0d", cur_word, rises), {31'd0, i2s_sdata}, {31'd0, exp_bit});
            chk($sformatf("lrclk_r%0d", rises), {31'd0, i2s_lrclk}, (rises >= 32) ? 32'd1 : 32'd0);
            rises++;
        end
        prev_bclk = i2s_bclk;
        prev_fs   = frame_start;
    endtask

    // Runs table rows [base, base+n) as consecutive frames; load of frame f at cycle 512*f.
    task automatic run_phase(input int base, input int n, input int last_cyc);
        int fi, ph;
        mute = tbl[base].mute;
        for (int cyc = 0; cyc <= last_cyc; cyc++) begin
            fi = cyc / 512;
            ph = cyc % 512;
            bit_clk_en    = (cyc % 4 == 0);
            sample_clk_en = 1'b0;
            if (ph == 511 && fi + 1 < n && tbl[base + fi + 1].mode == MODE_PRE) begin
                sample_clk_en = 1'b1;
                sample_in     = tbl[base + fi + 1].smp;
            end
            if (ph == 0 && fi < n) begin
                if (tbl[base + fi].mode == MODE_COIN) begin
                    sample_clk_en = 1'b1;
                    sample_in     = tbl[base + fi].smp;
                end
                exq.push_back('{word: tbl[base + fi].exp_word, ur: tbl[base + fi].exp_ur});
            end
            if (ph == 256 && fi + 1 < n) mute = tbl[base + fi + 1].mute;
            @(posedge master_clk);
            #1;
            monitor(bit_clk_en);
        end
        bit_clk_en    = 1'b0;
        sample_clk_en = 1'b0;
    endtask

    task automatic reset_monitor();
        have_frame = 1'b0;
        prev_bclk  = 1'b0;
        prev_fs    = 1'b0;
        en_cnt     = 0;
        rises      = 0;
    endtask

    initial begin
        // Phase 1 (rows 0..12): start-up underrun, 8001 pattern, coincident load, repeated
        // 7FFF with underruns, mute raised mid-frame over AAAA, un-mute, full-scale word.
        tbl[0]  = '{MODE_NONE, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[1]  = '{MODE_PRE,  16'h8001, 1'b0, 16'h8001, 1'b0};
        tbl[2]  = '{MODE_COIN, 16'h1234, 1'b0, 16'h1234, 1'b0};
        tbl[3]  = '{MODE_NONE, 16'h0000, 1'b0, 16'h1234, 1'b1};
        tbl[4]  = '{MODE_PRE,  16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        tbl[5]  = '{MODE_NONE, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
        tbl[6]  = '{MODE_NONE, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
        tbl[7]  = '{MODE_PRE,  16'hAAAA, 1'b0, 16'hAAAA, 1'b0};
        tbl[8]  = '{MODE_PRE,  16'h5555, 1'b1, 16'h0000, 1'b0};
        tbl[9]  = '{MODE_NONE, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[10] = '{MODE_PRE,  16'h0F0F, 1'b0, 16'h0F0F, 1'b0};
        tbl[11] = '{MODE_PRE,  16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        tbl[12] = '{MODE_NONE, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
        // Phase 2 (rows 13..15): after a mid-frame reset the held sample is gone.
        tbl[13] = '{MODE_NONE, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[14] = '{MODE_PRE,  16'h8001, 1'b0, 16'h8001, 1'b0};
        tbl[15] = '{MODE_NONE, 16'h0000, 1'b0, 16'h8001, 1'b1};

        repeat (3) @(posedge master_clk);
        #1;
        chk_outputs_zero("reset");
        #4 rst = 1'b0;

        run_phase(0, 13, 12 * 512 + 300);
        chk("pre_reset_bclk_high", {31'd0, i2s_bclk}, 32'd1);
        chk("pre_reset_lrclk_high", {31'd0, i2s_lrclk}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        chk("phase1_queue_empty", exq.size(), 32'd0);
        repeat (2) @(posedge master_clk);
        #5 rst = 1'b0;
        reset_monitor();

        run_phase(13, 3, 3 * 512 - 2);
        chk("frames_seen", frames_seen, 32'd16);
        chk("queue_empty", exq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
